// File: rtl/collector3x3_ctrl_if.sv
// Pixel-in / window-out handshake bundle between the stream source, the
// collector3x3_ctrl sequencer and the downstream MAC stage.
interface collector3x3_ctrl_if #(
    parameter int IMAGE_WIDTH  = 256,
    parameter int IMAGE_HEIGHT = IMAGE_WIDTH
);
    localparam int RW = $clog2(IMAGE_HEIGHT);
    localparam int CW = $clog2(IMAGE_WIDTH);

    logic [7:0]    in_pixel;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    col_pixel;
    logic          col_shift;
    logic          win_valid;
    logic          out_ready;
    logic [RW-1:0] win_row;
    logic [CW-1:0] win_col;
    logic          win_first;
    logic          win_last;

    // Controller side
    modport slave (
        input  in_pixel, in_valid, out_ready,
        output in_ready, col_pixel, col_shift,
        output win_valid, win_row, win_col, win_first, win_last
    );

    // Stream source / window sink side
    modport master (
        output in_pixel, in_valid, out_ready,
        input  in_ready, col_pixel, col_shift,
        input  win_valid, win_row, win_col, win_first, win_last
    );
endinterface

// File: rtl/collector3x3_ctrl.sv
// Frame sequencer for the 3x3 window collector: raster tracking, window flagging, flush/done.
// Optional stride-2 window selection is enabled by defining COLLECTOR_CTRL_STRIDE2_EN.
module collector3x3_ctrl #(
    parameter int IMAGE_WIDTH  = 256,
    parameter int IMAGE_HEIGHT = IMAGE_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    collector3x3_ctrl_if.slave bus,
    output logic               busy,
    output logic               frame_done
);
    localparam int RW = $clog2(IMAGE_HEIGHT);
    localparam int CW = $clog2(IMAGE_WIDTH);

    localparam logic [RW-1:0] ROW_ONE = RW'(1);
    localparam logic [RW-1:0] ROW_TWO = RW'(2);
    localparam logic [CW-1:0] COL_TWO = CW'(2);
    localparam logic [RW-1:0] ROW_END = RW'(IMAGE_HEIGHT - 1);
    localparam logic [CW-1:0] COL_END = CW'(IMAGE_WIDTH - 1);

`ifdef COLLECTOR_CTRL_STRIDE2_EN
    // Bottom-right pixel of the last even-aligned window
    localparam logic [RW-1:0] LAST_WIN_ROW = RW'(2 * ((IMAGE_HEIGHT - 1) / 2));
    localparam logic [CW-1:0] LAST_WIN_COL = CW'(2 * ((IMAGE_WIDTH - 1) / 2));
`else
    localparam logic [RW-1:0] LAST_WIN_ROW = ROW_END;
    localparam logic [CW-1:0] LAST_WIN_COL = COL_END;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t        state, state_nx;
    logic [RW-1:0] row;
    logic [CW-1:0] col;

    logic          accept;
    logic          at_eol;
    logic          at_eof;
    logic          qualify;
    logic          win_xfer;

    logic          win_valid_q;
    logic [RW-1:0] win_row_q;
    logic [CW-1:0] win_col_q;
    logic          win_first_q;
    logic          win_last_q;

    // Upstream only moves when downstream can take a window, so the collector
    // never shifts past a window that has not been consumed.
    assign bus.in_ready  = ((state == FILL) || (state == RUN)) && bus.out_ready;
    assign bus.col_pixel = bus.in_pixel;
    assign bus.col_shift = accept;

    assign accept   = bus.in_valid && bus.in_ready;
    assign at_eol   = (col == COL_END);
    assign at_eof   = at_eol && (row == ROW_END);
    assign win_xfer = win_valid_q && bus.out_ready;

`ifdef COLLECTOR_CTRL_STRIDE2_EN
    // (r-2) even <=> r even
    assign qualify = accept && (row >= ROW_TWO) && (col >= COL_TWO) && !row[0] && !col[0];
`else
    assign qualify = accept && (row >= ROW_TWO) && (col >= COL_TWO);
`endif

    // Raster position of the next pixel to be accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if ((state == IDLE) && start) begin
            row <= '0;
            col <= '0;
        end else if (accept) begin
            if (at_eol) begin
                col <= '0;
                row <= at_eof ? '0 : row + ROW_ONE;
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Window descriptor: loaded on the same edge the collector captures the pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            win_valid_q <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
            win_first_q <= 1'b0;
            win_last_q  <= 1'b0;
        end else if (qualify) begin
            win_valid_q <= 1'b1;
            win_row_q   <= row - ROW_TWO;
            win_col_q   <= col - COL_TWO;
            win_first_q <= (row == ROW_TWO) && (col == COL_TWO);
            win_last_q  <= (row == LAST_WIN_ROW) && (col == LAST_WIN_COL);
        end else if (win_xfer) begin
            win_valid_q <= 1'b0;
        end
    end

    assign bus.win_valid = win_valid_q;
    assign bus.win_row   = win_row_q;
    assign bus.win_col   = win_col_q;
    assign bus.win_first = win_first_q;
    assign bus.win_last  = win_last_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        frame_done = 1'b0;
        unique case (state)
            IDLE:  if (start) state_nx = FILL;
            FILL:  if (accept && at_eol && (row == ROW_ONE)) state_nx = RUN;
            RUN:   if (accept && at_eof) state_nx = FLUSH;
            // Done once nothing is pending or the pending last window leaves
            FLUSH: if (!win_valid_q || bus.out_ready) begin
                frame_done = 1'b1;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // A stalled window must stay frozen until the sink takes it
    a_hold_on_stall: assert property (@(posedge clk) disable iff (rst)
        (win_valid_q && !bus.out_ready) |=> (win_valid_q && $stable(win_row_q) && $stable(win_col_q)));

    a_done_in_flush: assert property (@(posedge clk) disable iff (rst)
        frame_done |-> (state == FLUSH));
endmodule

// File: tb/tb_collector3x3_ctrl.sv
// Randomized scoreboard bench for collector3x3_ctrl on an 8x8 frame.
module tb_collector3x3_ctrl;
    localparam int W    = 8;
    localparam int H    = 8;
    localparam int NPIX = W * H;

    typedef struct {
        int r;
        int c;
        bit f;
        bit l;
    } win_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy, frame_done;

    collector3x3_ctrl_if #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) bus ();

    collector3x3_ctrl #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    win_t q[$];
    bit   in_frame = 0;
    int   tot_px = 0;
    int   frames_done = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Window selection straight from the frame geometry
    function automatic bit qualifies(input int r, input int c);
`ifdef COLLECTOR_CTRL_STRIDE2_EN
        return (r >= 2) && (c >= 2) && ((r - 2) % 2 == 0) && ((c - 2) % 2 == 0);
`else
        return (r >= 2) && (c >= 2);
`endif
    endfunction

    function automatic bit is_last(input int r, input int c);
`ifdef COLLECTOR_CTRL_STRIDE2_EN
        return (r == 2 * ((H - 1) / 2)) && (c == 2 * ((W - 1) / 2));
`else
        return (r == H - 1) && (c == W - 1);
`endif
    endfunction

    // One clock of stimulus; the model decides acceptance, not the DUT
    task automatic cycle(input logic v, input logic o, input logic st, input logic [7:0] px);
        logic exp_rdy, acc, take_start;
        win_t w;
        int r, c;
        @(negedge clk);
        bus.in_valid  = v;
        bus.out_ready = o;
        bus.in_pixel  = px;
        start         = st;
        #1;
        exp_rdy    = in_frame && (tot_px < NPIX) && o;
        acc        = v && exp_rdy;
        take_start = st && !in_frame;
        chk("in_ready", bus.in_ready, exp_rdy);
        chk("col_shift", bus.col_shift, acc);
        chk("col_pixel", bus.col_pixel, px);
        @(posedge clk);
        if (take_start) begin
            in_frame = 1;
            tot_px   = 0;
        end else if (acc) begin
            r = tot_px / W;
            c = tot_px % W;
            if (qualifies(r, c)) begin
                w.r = r - 2;
                w.c = c - 2;
                w.f = (r == 2) && (c == 2);
                w.l = is_last(r, c);
                q.push_back(w);
            end
            tot_px++;
        end
    endtask

    task automatic do_reset_and_check();
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        start = 1'b0;
        @(posedge clk);
        in_frame = 0;
        tot_px   = 0;
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_col_shift", bus.col_shift, 0);
        chk("rst_win_valid", bus.win_valid, 0);
        chk("rst_win_row", 32'(bus.win_row), 0);
        chk("rst_win_col", 32'(bus.win_col), 0);
        chk("rst_win_first", bus.win_first, 0);
        chk("rst_win_last", bus.win_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
    endtask

    // mode: 0 full rate, 1 downstream stall, 2 upstream 1-on/2-off, 3 random
    task automatic run_frame(input int mode, input int rst_at);
        logic v, o, st;
        int   k = 0;
        int   stall = 0;
        cycle(1'b0, 1'b1, 1'b1, 8'd0);
        while (in_frame && tot_px < NPIX && k < 20000) begin
            if (rst_at >= 0 && tot_px == rst_at) begin
                do_reset_and_check();
                return;
            end
            v = 1'b1; o = 1'b1; st = 1'b0;
            case (mode)
                1: if (tot_px == 4 * W + 3 && stall < 5) begin o = 1'b0; stall++; end
                2: v = (k % 3 == 0);
                3: begin
                    v  = ($urandom_range(0, 3) != 0);
                    o  = ($urandom_range(0, 3) != 0);
                    st = ($urandom_range(0, 15) == 0);
                end
                default: ;
            endcase
            cycle(v, o, st, (mode == 3) ? 8'($urandom) : 8'(tot_px % W));
            k++;
        end
        k = 0;
        while (in_frame && k < 100) begin
            o = (mode == 3) ? 1'($urandom_range(0, 1)) : 1'b1;
            cycle(1'b1, o, 1'b0, 8'd0);
            k++;
        end
        chk("frame_end_timeout", in_frame, 0);
        chk("leftover_windows", q.size(), 0);
    endtask

    // Monitor: samples just before the next active edge and scores transfers
    initial begin
        win_t w;
        bit   xfer, exp_done;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                xfer     = bus.win_valid && bus.out_ready;
                exp_done = in_frame && (tot_px == NPIX) &&
                           ((q.size() == 0) || ((q.size() == 1) && xfer));
                chk("win_valid", bus.win_valid, (q.size() != 0));
                chk("busy", busy, in_frame);
                chk("frame_done", frame_done, exp_done);
                if (exp_done) begin
                    in_frame = 0;
                    frames_done++;
                end
                if (xfer && q.size() != 0) begin
                    w = q.pop_front();
                    chk("win_row", 32'(bus.win_row), w.r);
                    chk("win_col", 32'(bus.win_col), w.c);
                    chk("win_first", bus.win_first, w.f);
                    chk("win_last", bus.win_last, w.l);
                end
            end
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_pixel  = 8'd0;
        repeat (2) @(posedge clk);
        do_reset_and_check();

        run_frame(0, -1);
        run_frame(1, -1);
        run_frame(2, -1);
        run_frame(3, -1);
        run_frame(0, 30);
        run_frame(0, -1);
        run_frame(3, -1);

        repeat (3) cycle(1'b0, 1'b1, 1'b0, 8'd0);
        chk("frames_done", frames_done, 6);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
